bist_cut: RTL and testbench

- Small sequential circuit-under-test for the per-scan BIST flow: a read-address sequencer that handshakes with an external lamp/data source and freezes on completion.
- All state flops are also stitched into two scan chains driven from test_in and observed on test_out.
- Sits inside the BIST wrapper; the wrapper drives scan (s) and the chains.

---
 rtl/bist_cut_pkg.sv | 19 +
 rtl/bist_cut_scan_reg.sv | 26 ++
 rtl/bist_cut.sv | 97 +++++++++
 tb/tb_bist_cut.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bist_cut_pkg.sv
// Shared definitions for the bist_cut read-address sequencer and its scan chains.
package bist_cut_pkg;

  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned TMO_W      = 4;
  localparam int unsigned ST_W       = 3;
  localparam int unsigned CHAIN0_LEN = 8;  // state[2:0] + read_a[4:0]
  localparam int unsigned CHAIN1_LEN = 6;  // tmo[3:0] + lclk + fz_L

  // Codes 5..7 are illegal and fall back to IDLE on the next functional clock.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAPT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/bist_cut_scan_reg.sv
// Generic width-N register with a scan mux: loads d in functional mode,
// shifts scan_in towards the MSB when se is high. q[N-1] is the chain tail.
module bist_cut_scan_reg #(
  parameter int unsigned   N       = 2,
  parameter logic [N-1:0]  RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         se,
  input  logic         scan_in,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Reset wins over shift, shift wins over functional load.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (se) begin
      q <= {q[N-2:0], scan_in};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/bist_cut.sv
// Read-address sequencer under BIST: requests data from an external source,
// waits for acknowledge (with timeout), steps the address and freezes when done.
// All state lives in two scan chains built from bist_cut_scan_reg.
module bist_cut #(
  parameter int unsigned ADDR_W = bist_cut_pkg::ADDR_W,
  parameter int unsigned TMO_W  = bist_cut_pkg::TMO_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s,
  input  logic              dv,
  input  logic              l_in,
  input  logic [1:0]        test_in,
  output logic              fz_L,
  output logic              lclk,
  output logic [ADDR_W-1:0] read_a,
  output logic [1:0]        test_out
);

  import bist_cut_pkg::*;

  localparam int unsigned C0 = ST_W + ADDR_W;
  localparam int unsigned C1 = TMO_W + 2;
  localparam logic [C1-1:0] C1_RST = {1'b1, {(C1-1){1'b0}}};

  logic [C0-1:0]     c0_d, c0_q;
  logic [C1-1:0]     c1_d, c1_q;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] read_a_nxt;
  logic [TMO_W-1:0]  tmo, tmo_nxt;

  // Chain bit order follows the shift path: chain0 = {read_a, state},
  // chain1 = {fz_L, lclk, tmo}, LSB nearest test_in.
  assign state    = state_t'(c0_q[ST_W-1:0]);
  assign read_a   = c0_q[C0-1:ST_W];
  assign tmo      = c1_q[TMO_W-1:0];
  assign lclk     = c1_q[TMO_W];
  assign fz_L     = c1_q[TMO_W+1];
  assign test_out = {c1_q[C1-1], c0_q[C0-1]};

  // Next-state, address/timeout update and Moore outputs derived from next state.
  always_comb begin
    state_nxt  = state;
    read_a_nxt = read_a;
    tmo_nxt    = tmo;
    case (state)
      ST_IDLE: begin
        if (dv) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        tmo_nxt   = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (l_in) begin
          state_nxt = ST_CAPT;
        end else if (tmo == '1) begin
          state_nxt = ST_DONE;
        end else begin
          tmo_nxt = tmo + TMO_W'(1);
        end
      end
      ST_CAPT: begin
        read_a_nxt = read_a + ADDR_W'(1);
        state_nxt  = (read_a == '1) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        if (!dv) begin
          state_nxt  = ST_IDLE;
          read_a_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    c0_d = {read_a_nxt, state_nxt};
    c1_d = {(state_nxt != ST_DONE), (state_nxt == ST_REQ), tmo_nxt};
  end

  bist_cut_scan_reg #(.N(C0), .RST_VAL('0)) u_chain0 (
    .clock   (clock),
    .reset   (reset),
    .se      (s),
    .scan_in (test_in[0]),
    .d       (c0_d),
    .q       (c0_q)
  );

  bist_cut_scan_reg #(.N(C1), .RST_VAL(C1_RST)) u_chain1 (
    .clock   (clock),
    .reset   (reset),
    .se      (s),
    .scan_in (test_in[1]),
    .d       (c1_d),
    .q       (c1_q)
  );

endmodule

// File: tb/tb_bist_cut.sv
// Directed testbench for bist_cut: reset, full address sweep, timeout abort,
// DONE hold, scan shifting with illegal-state recovery, and mid-sequence reset.
module tb_bist_cut;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       s = 1'b0;
  logic       dv = 1'b0;
  logic       l_in = 1'b0;
  logic [1:0] test_in = 2'b00;
  logic       fz_L;
  logic       lclk;
  logic [4:0] read_a;
  logic [1:0] test_out;

  int n_checks = 0;
  int n_fail   = 0;

  bist_cut #(.ADDR_W(5), .TMO_W(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .s        (s),
    .dv       (dv),
    .l_in     (l_in),
    .test_in  (test_in),
    .fz_L     (fz_L),
    .lclk     (lclk),
    .read_a   (read_a),
    .test_out (test_out)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset, then idle for 7 clocks
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("idle_fz", fz_L, 1);
      check("idle_lclk", lclk, 0);
      check("idle_addr", read_a, 0);
      check("idle_tout", test_out, 2'b10);
    end

    // Full sweep with acknowledge always present
    dv = 1'b1; l_in = 1'b1;
    tick();
    check("sweep_first_lclk", lclk, 1);
    check("sweep_first_addr", read_a, 0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("sweep_wait_lclk", lclk, 0);
      check("sweep_wait_state", dut.state, 2);
      tick();
      check("sweep_capt_lclk", lclk, 0);
      check("sweep_capt_state", dut.state, 3);
      tick();
      check("sweep_addr", read_a, k % 32);
      if (k < 32) begin
        check("sweep_lclk", lclk, 1);
        check("sweep_fz", fz_L, 1);
      end else begin
        check("sweep_end_lclk", lclk, 0);
        check("sweep_end_fz", fz_L, 0);
        check("sweep_end_tout", test_out, 2'b00);
      end
    end

    // DONE holds while dv stays high
    for (int i = 0; i < 10; i++) begin
      tick();
      check("done_hold_fz", fz_L, 0);
      check("done_hold_addr", read_a, 0);
      check("done_hold_lclk", lclk, 0);
    end
    dv = 1'b0;
    tick();
    check("done_exit_fz", fz_L, 1);
    check("done_exit_state", dut.state, 0);
    check("done_exit_addr", read_a, 0);

    // Timeout abort: no acknowledge
    dv = 1'b1; l_in = 1'b0;
    tick();
    check("tmo_req_lclk", lclk, 1);
    tick();
    check("tmo_wait_lclk", lclk, 0);
    check("tmo_wait_tmo0", dut.tmo, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("tmo_wait_fz", fz_L, 1);
      check("tmo_wait_state", dut.state, 2);
      check("tmo_wait_lclk2", lclk, 0);
    end
    check("tmo_at_limit", dut.tmo, 15);
    tick();
    check("tmo_abort_fz", fz_L, 0);
    check("tmo_abort_addr", read_a, 0);
    check("tmo_abort_state", dut.state, 4);
    dv = 1'b0;
    tick();
    check("tmo_exit_fz", fz_L, 1);

    // Scan: flush zeros, then shift ones through both chains
    s = 1'b1; test_in = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    check("scan_zero_tout", test_out, 2'b00);
    check("scan_zero_fz", fz_L, 0);
    test_in = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("scan_tout0", test_out[0], (i >= 8) ? 1 : 0);
      check("scan_tout1", test_out[1], (i >= 6) ? 1 : 0);
    end
    check("scan_state7", dut.state, 7);
    check("scan_addr", read_a, 31);
    check("scan_lclk", lclk, 1);
    check("scan_tmo", dut.tmo, 15);
    s = 1'b0; test_in = 2'b00; dv = 1'b0;
    tick();
    check("illegal_recover_state", dut.state, 0);
    check("illegal_recover_lclk", lclk, 0);
    check("illegal_recover_fz", fz_L, 1);
    check("illegal_recover_addr", read_a, 31);
    check("illegal_recover_tout", test_out, 2'b11);

    // Reset mid-WAIT at read_a=5
    reset = 1'b1; tick(); reset = 1'b0;
    dv = 1'b1; l_in = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("mid_addr5", read_a, 5);
    check("mid_req_lclk", lclk, 1);
    l_in = 1'b0;
    tick(); tick(); tick();
    check("mid_wait_state", dut.state, 2);
    reset = 1'b1;
    tick();
    check("mid_rst_addr", read_a, 0);
    check("mid_rst_lclk", lclk, 0);
    check("mid_rst_fz", fz_L, 1);
    check("mid_rst_state", dut.state, 0);

    // Reset wins over scan shifting
    reset = 1'b0; s = 1'b1; test_in = 2'b01;
    tick(); tick(); tick();
    check("shift_state_pre", dut.state, 7);
    reset = 1'b1;
    tick();
    check("shift_rst_tout", test_out, 2'b10);
    check("shift_rst_state", dut.state, 0);
    check("shift_rst_lclk", lclk, 0);
    reset = 1'b0; s = 1'b0; dv = 1'b0; test_in = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
